// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_controller
//  Purpose  : Single-outstanding memory access controller. Accepts read
//             bursts (1-4 beats) and single-word writes, range-checks them
//             against MEM_WORDS, drives a registered-read main memory through
//             MAR/MBR, and returns one-cycle response pulses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_controller #(
   parameter int MEM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        reset,
   // request channel
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_len,
   // response channel (no backpressure)
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_last,
   output logic        rsp_error,
   // main-memory port
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_out,
   output logic        mem_write_enable,
   input  logic [15:0] mem_data_in,
   // observability
   output logic [15:0] mar,
   output logic [15:0] mbr
);

   // Highest legal word address, widened so the range sum cannot overflow.
   localparam logic [16:0] LAST_ADDR = 17'(MEM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t      state_q;
   logic [15:0] mar_q;
   logic [15:0] mbr_q;
   logic [1:0]  cnt_q;
   logic        rsp_valid_q;
   logic        rsp_last_q;
   logic        rsp_error_q;
   logic [15:0] rsp_data_q;

   logic        accept;
   logic [1:0]  eff_len;
   logic [16:0] end_addr;
   logic        out_of_range;

   // Handshake and range check. Writes are always one word, so their length
   // field is forced to zero before the end address is formed.
   assign req_ready    = (state_q == S_IDLE) && !reset;
   assign accept       = req_valid && req_ready;
   assign eff_len      = req_write ? 2'd0 : req_len;
   assign end_addr     = {1'b0, req_addr} + {15'd0, eff_len};
   assign out_of_range = (end_addr > LAST_ADDR);

   // Memory strobe is gated by reset so an abandoned write never lands.
   assign mem_write_enable = (state_q == S_WRITE) && !reset;
   assign mem_addr         = mar_q;
   assign mem_data_out     = mbr_q;
   assign mar              = mar_q;
   assign mbr              = mbr_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_error = rsp_error_q;
   assign rsp_data  = rsp_data_q;

   // Transaction FSM with MAR/MBR datapath and registered response pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mar_q       <= 16'd0;
         mbr_q       <= 16'd0;
         cnt_q       <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= 16'd0;
      end else begin
         // Response outputs are single-cycle pulses unless re-armed below.
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= 16'd0;

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mar_q <= req_addr;
                  if (out_of_range) begin
                     // MBR deliberately left untouched on a rejected request.
                     state_q <= S_ERR;
                  end else if (req_write) begin
                     mbr_q   <= req_wdata;
                     state_q <= S_WRITE;
                  end else begin
                     cnt_q   <= req_len;
                     state_q <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               // Memory registers mem_addr at the edge leaving this state.
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               mbr_q       <= mem_data_in;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= mem_data_in;
               rsp_last_q  <= (cnt_q == 2'd0);
               if (cnt_q != 2'd0) begin
                  mar_q   <= mar_q + 16'd1;
                  cnt_q   <= cnt_q - 2'd1;
                  state_q <= S_ISSUE;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_WRITE: begin
               rsp_valid_q <= 1'b1;
               rsp_last_q  <= 1'b1;
               rsp_data_q  <= mbr_q;
               state_q     <= S_IDLE;
            end

            S_ERR: begin
               rsp_valid_q <= 1'b1;
               rsp_last_q  <= 1'b1;
               rsp_error_q <= 1'b1;
               rsp_data_q  <= 16'd0;
               state_q     <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Qualifiers on the response channel only ever accompany a valid beat.
   a_rsp_qualifiers: assert property (@(posedge clk) disable iff (reset)
      !rsp_valid |-> (!rsp_last && !rsp_error));

   // A burst that still has beats left can always step MAR without leaving
   // the memory, because the acceptance check covered the whole burst.
   a_mar_no_wrap: assert property (@(posedge clk) disable iff (reset)
      (state_q == S_WAIT && cnt_q != 2'd0) |-> ({1'b0, mar_q} < LAST_ADDR));

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_controller
//  Purpose  : Scoreboard bench for mem_access_controller with a registered
//             read memory model and a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_controller;

   localparam int MEM_WORDS = 16384;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = 16'd0;
   logic [15:0] req_wdata = 16'd0;
   logic [1:0]  req_len = 2'd0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_last;
   logic        rsp_error;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_out;
   logic        mem_write_enable;
   logic [15:0] mem_data_in = 16'd0;
   logic [15:0] mar;
   logic [15:0] mbr;

   mem_access_controller #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_len          (req_len),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .rsp_last         (rsp_last),
      .rsp_error        (rsp_error),
      .mem_addr         (mem_addr),
      .mem_data_out     (mem_data_out),
      .mem_write_enable (mem_write_enable),
      .mem_data_in      (mem_data_in),
      .mar              (mar),
      .mbr              (mbr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        err;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;

   rsp_t        rsp_q[$];
   wr_t         wr_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          next_ready_cyc = 0;
   bit          contiguous = 1'b0;
   bit          mem_init = 1'b0;
   logic [15:0] mem     [0:MEM_WORDS-1];
   logic [15:0] ref_mem [0:MEM_WORDS-1];

   // Deterministic power-up contents shared by memory model and reference.
   function automatic logic [15:0] init_val(input int i);
      if (i >= 256 && i <= 259) return 16'(i - 255);   // 0x0100..0x0103 = 1..4
      if (i == 512) return 16'h5A5A;                    // 0x0200 old value
      return 16'((i * 40503) ^ 16'h5A5A);
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Main memory: write strobe and registered read, both on the rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_init) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
         mem_init <= 1'b1;
      end else begin
         if (mem_write_enable && int'(mem_addr) < MEM_WORDS) mem[mem_addr] <= mem_data_out;
         mem_data_in <= (int'(mem_addr) < MEM_WORDS) ? mem[mem_addr] : 16'h0000;
      end
   end

   // Monitor: pops expected writes and responses whenever the DUT shows one.
   always @(negedge clk) begin
      wr_t  we;
      rsp_t re;
      if (mem_write_enable) begin
         total++;
         if (reset) begin
            bad++;
            $display("FAIL wr_during_reset: got strobe addr=%h want none", mem_addr);
         end else if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h want none", mem_addr, mem_data_out);
         end else begin
            we = wr_q.pop_front();
            if (mem_addr !== we.addr || mem_data_out !== we.data || cyc != we.cyc) begin
               bad++;
               $display("FAIL mem_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                        mem_addr, mem_data_out, cyc, we.addr, we.data, we.cyc);
            end
         end
      end
      if (!reset) begin
         if (rsp_valid) begin
            total++;
            if (rsp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_rsp: got data=%h last=%b err=%b want none",
                        rsp_data, rsp_last, rsp_error);
            end else begin
               re = rsp_q.pop_front();
               if (rsp_data !== re.data || rsp_last !== re.last || rsp_error !== re.err || cyc != re.cyc) begin
                  bad++;
                  $display("FAIL rsp: got data=%h last=%b err=%b cyc=%0d want data=%h last=%b err=%b cyc=%0d",
                           rsp_data, rsp_last, rsp_error, cyc, re.data, re.last, re.err, re.cyc);
               end
            end
         end else if (rsp_last || rsp_error) begin
            total++;
            bad++;
            $display("FAIL stray_qualifier: got last=%b err=%b want 0 0", rsp_last, rsp_error);
         end
      end
   end

   // Reference model: request accepted at the edge after cycle c.
   task automatic model(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] l, input int c);
      int   len;
      rsp_t r;
      len = w ? 0 : int'(l);
      if (int'(a) + len > MEM_WORDS - 1) begin
         r = '{16'h0000, 1'b1, 1'b1, c + 2};
         rsp_q.push_back(r);
         next_ready_cyc = c + 2;
      end else if (w) begin
         wr_q.push_back('{a, d, c + 1});
         ref_mem[a] = d;
         r = '{d, 1'b1, 1'b0, c + 2};
         rsp_q.push_back(r);
         next_ready_cyc = c + 2;
      end else begin
         for (int i = 0; i <= len; i++) begin
            r = '{ref_mem[int'(a) + i], (i == len), 1'b0, c + 3 + 2 * i};
            rsp_q.push_back(r);
         end
         next_ready_cyc = c + 3 + 2 * len;
      end
   endtask

   // Hold req_valid high, scrambling fields while busy, then present the
   // intended request in the cycle req_ready rises.
   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] l);
      int waited;
      waited = 0;
      req_valid = 1'b1;
      while (!req_ready) begin
         req_write = 1'($urandom);
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         req_len   = 2'($urandom);
         @(negedge clk); #1;
         waited++;
         if (waited > 40) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles want ready", waited);
            req_valid  = 1'b0;
            contiguous = 1'b0;
            return;
         end
      end
      if (contiguous) check("ready_time", 32'(cyc), 32'(next_ready_cyc));
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_len   = l;
      model(w, a, d, l, cyc);
      @(negedge clk); #1;
      contiguous = 1'b1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin @(negedge clk); #1; end
      contiguous = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      req_valid = 1'b0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0) && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      check("drain_outstanding", 32'(rsp_q.size() + wr_q.size()), 32'd0);
      rsp_q.delete();
      wr_q.delete();
      @(negedge clk); #1;
      contiguous = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;

      // Reset state
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_mar", 32'(mar), 32'd0);
      check("rst_mbr", 32'(mbr), 32'd0);
      check("rst_we", 32'(mem_write_enable), 32'd0);

      // Directed write then read-back
      issue(1'b1, 16'h0010, 16'hBEEF, 2'd0);
      drain();
      check("mem_0010_after_write", 32'(mem[16'h0010]), 32'h0000BEEF);
      issue(1'b0, 16'h0010, 16'h0000, 2'd0);
      drain();

      // Four-beat burst over preloaded 1,2,3,4
      issue(1'b0, 16'h0100, 16'h0000, 2'd3);
      drain();
      check("burst_final_mar", 32'(mar), 32'h00000103);

      // Out-of-range read and write
      issue(1'b0, 16'h3FFE, 16'h0000, 2'd2);
      drain();
      issue(1'b1, 16'h4000, 16'h1111, 2'd0);
      drain();

      // Reset while the write is in its WRITE cycle
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0200;
      req_wdata = 16'h1234;
      req_len   = 2'd0;
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      check("ready_after_reset", 32'(req_ready), 32'd1);
      check("mar_after_reset", 32'(mar), 32'd0);
      check("mbr_after_reset", 32'(mbr), 32'd0);
      check("mem_0200_kept", 32'(mem[16'h0200]), 32'h00005A5A);
      contiguous = 1'b0;
      issue(1'b0, 16'h0200, 16'h0000, 2'd0);
      drain();

      // req_valid held through a burst: next request waits for the last beat
      issue(1'b0, 16'h0100, 16'h0000, 2'd3);
      issue(1'b1, 16'h0300, 16'hCAFE, 2'd0);
      issue(1'b0, 16'h0300, 16'h0000, 2'd0);
      drain();

      // Randomized back-to-back traffic with occasional gaps
      for (int t = 0; t < 300; t++) begin
         logic        w;
         logic [15:0] a;
         logic [1:0]  l;
         int          sel;
         w   = ($urandom_range(0, 9) < 4);
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 16'(MEM_WORDS - 4 + $urandom_range(0, 7));
         else if (sel == 1) a = 16'($urandom);
         else               a = 16'($urandom_range(0, MEM_WORDS - 1));
         l = 2'($urandom);
         issue(w, a, 16'($urandom), l);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
